// File: rtl/nes_mem_2port.sv
// nes_mem_2port: shared byte array with an instruction-fetch port (FETCH_BYTES
// consecutive bytes) and a byte-wide data port. Reads are registered with
// RD_LATENCY cycles of latency; an optional init sequencer fills the array with
// FILL_BYTE after reset before either port reports ready.
// Optional feature: define MEM_WRITE_PROTECT_EN to drop data writes at or above
// ROM_BASE and pulse wp_err_o for each dropped write.
`timescale 1ns / 1ps

module nes_mem_2port #(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned FETCH_BYTES   = 3,
    parameter int unsigned RD_LATENCY    = 1,
    parameter int unsigned INIT_ON_RESET = 1,
    parameter logic [7:0]  FILL_BYTE     = 8'hEA,
    parameter int unsigned ROM_BASE      = 2**ADDR_W - 2**(ADDR_W-2)
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     if_req_i,
    input  logic [ADDR_W-1:0]        if_addr_i,
    output logic                     if_ready_o,
    output logic                     if_valid_o,
    output logic [8*FETCH_BYTES-1:0] if_data_o,
    input  logic                     d_req_i,
    input  logic                     d_we_i,
    input  logic [ADDR_W-1:0]        d_addr_i,
    input  logic [7:0]               d_wdata_i,
    output logic                     d_ready_o,
    output logic                     d_valid_o,
    output logic [7:0]               d_rdata_o,
    output logic                     wp_err_o
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned IF_W  = 8*FETCH_BYTES;

    if (FETCH_BYTES < 1 || FETCH_BYTES > 4) begin : g_bad_fetch_bytes
        $error("nes_mem_2port: FETCH_BYTES must be in 1..4");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_rd_latency
        $error("nes_mem_2port: RD_LATENCY must be in 1..4");
    end

    typedef enum logic {StInit, StRun} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              ready_q;

    logic [7:0] mem [DEPTH];

    logic              if_acc;
    logic              d_acc;
    logic              d_rd;
    logic              d_wr;
    logic              wp_hit;
    logic              init_we;
    logic [IF_W-1:0]   if_rd_data;
    logic [7:0]        d_rd_data;
    logic [ADDR_W-1:0] fetch_addr [FETCH_BYTES];

    logic [RD_LATENCY-1:0] if_v_q;
    logic [IF_W-1:0]       if_pipe_q [RD_LATENCY];
    logic [RD_LATENCY-1:0] d_v_q;
    logic [7:0]            d_pipe_q  [RD_LATENCY];

    // ready_q is only ever set in RUN, so it gates both accept paths
    assign if_acc = if_req_i & ready_q;
    assign d_acc  = d_req_i & ready_q;
    assign d_rd   = d_acc & ~d_we_i;
    assign d_wr   = d_acc & d_we_i & ~wp_hit;
    // Qualified with rstn_i so the fill does not touch the array while held in reset
    assign init_we = rstn_i && (state_q == StInit);

`ifdef MEM_WRITE_PROTECT_EN
    localparam logic [ADDR_W:0] ROM_BASE_W = (ADDR_W+1)'(ROM_BASE);
    logic wp_err_q;

    assign wp_hit = d_acc & d_we_i & ({1'b0, d_addr_i} >= ROM_BASE_W);

    // One-cycle error pulse after a dropped write
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wp_err_q <= 1'b0;
        end else begin
            wp_err_q <= wp_hit;
        end
    end

    assign wp_err_o = wp_err_q;
`else
    assign wp_hit   = 1'b0;
    assign wp_err_o = 1'b0;
`endif

    // Fetch byte addresses wrap naturally at the ADDR_W-bit boundary
    always_comb begin
        if_rd_data = '0;
        for (int k = 0; k < FETCH_BYTES; k++) begin
            fetch_addr[k]        = if_addr_i + ADDR_W'(k);
            if_rd_data[8*k +: 8] = mem[fetch_addr[k]];
        end
    end

    assign d_rd_data = mem[d_addr_i];

    // Init/run sequencer with registered ready
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= (INIT_ON_RESET != 0) ? StInit : StRun;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    if (cnt_q == {ADDR_W{1'b1}}) begin
                        state_q <= StRun;
                        ready_q <= 1'b1;
                    end
                end
                StRun: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StRun;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Array write port; reads above sample the pre-edge value, giving read-first
    always_ff @(posedge clk_i) begin
        if (init_we) begin
            mem[cnt_q] <= FILL_BYTE;
        end else if (d_wr) begin
            mem[d_addr_i] <= d_wdata_i;
        end
    end

    // Read pipelines; data stages only load when valid passes so outputs hold
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            if_v_q <= '0;
            d_v_q  <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                if_pipe_q[i] <= '0;
                d_pipe_q[i]  <= '0;
            end
        end else begin
            if_v_q[0] <= if_acc;
            d_v_q[0]  <= d_rd;
            if (if_acc) begin
                if_pipe_q[0] <= if_rd_data;
            end
            if (d_rd) begin
                d_pipe_q[0] <= d_rd_data;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                if_v_q[i] <= if_v_q[i-1];
                d_v_q[i]  <= d_v_q[i-1];
                if (if_v_q[i-1]) begin
                    if_pipe_q[i] <= if_pipe_q[i-1];
                end
                if (d_v_q[i-1]) begin
                    d_pipe_q[i] <= d_pipe_q[i-1];
                end
            end
        end
    end

    assign if_ready_o = ready_q;
    assign d_ready_o  = ready_q;
    assign if_valid_o = if_v_q[RD_LATENCY-1];
    assign if_data_o  = if_pipe_q[RD_LATENCY-1];
    assign d_valid_o  = d_v_q[RD_LATENCY-1];
    assign d_rdata_o  = d_pipe_q[RD_LATENCY-1];

endmodule

// File: tb/tb_nes_mem_2port.sv
// Directed bench for nes_mem_2port with ADDR_W=8, FETCH_BYTES=3, RD_LATENCY=2.
`timescale 1ns / 1ps

module tb_nes_mem_2port;

`ifdef MEM_WRITE_PROTECT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        if_req_i;
    logic [7:0]  if_addr_i;
    logic        if_ready_o;
    logic        if_valid_o;
    logic [23:0] if_data_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [7:0]  d_addr_i;
    logic [7:0]  d_wdata_i;
    logic        d_ready_o;
    logic        d_valid_o;
    logic [7:0]  d_rdata_o;
    logic        wp_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    nes_mem_2port #(
        .ADDR_W        (8),
        .FETCH_BYTES   (3),
        .RD_LATENCY    (2),
        .INIT_ON_RESET (1),
        .FILL_BYTE     (8'hEA),
        .ROM_BASE      (192)
    ) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_ready_o (if_ready_o),
        .if_valid_o (if_valid_o),
        .if_data_o  (if_data_o),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_ready_o  (d_ready_o),
        .d_valid_o  (d_valid_o),
        .d_rdata_o  (d_rdata_o),
        .wp_err_o   (wp_err_o)
    );

    typedef enum int {OpWrite, OpRead, OpFetch} op_e;
    typedef struct {
        op_e        op;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [23:0] exp;
        bit         exp_wp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Counts edges from reset release until both ports are ready; bounded
    task automatic wait_ready(output int n, output bit saw_valid);
        n = 0;
        saw_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk_i);
            #1;
            n++;
            if (d_valid_o || if_valid_o) saw_valid = 1'b1;
            if (if_ready_o && d_ready_o) break;
        end
    endtask

    task automatic do_write(input string name, input logic [7:0] addr, input logic [7:0] data,
                            input bit exp_wp);
        @(negedge clk_i);
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = addr;
        d_wdata_i = data;
        @(posedge clk_i);
        #1;
        d_req_i = 1'b0;
        d_we_i  = 1'b0;
        chk({name, "_wp"}, 32'(wp_err_o), 32'(exp_wp));
        chk({name, "_novalid"}, 32'(d_valid_o), 0);
        @(posedge clk_i);
        #1;
        chk({name, "_wp_end"}, 32'(wp_err_o), 0);
        chk({name, "_novalid2"}, 32'(d_valid_o), 0);
    endtask

    task automatic do_read(input string name, input bit fetch, input logic [7:0] addr,
                           input logic [23:0] exp);
        @(negedge clk_i);
        if (fetch) begin
            if_req_i  = 1'b1;
            if_addr_i = addr;
        end else begin
            d_req_i  = 1'b1;
            d_we_i   = 1'b0;
            d_addr_i = addr;
        end
        @(posedge clk_i);
        #1;
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
        chk({name, "_early"}, 32'(fetch ? if_valid_o : d_valid_o), 0);
        @(posedge clk_i);
        #1;
        chk({name, "_valid"}, 32'(fetch ? if_valid_o : d_valid_o), 1);
        chk({name, "_data"}, fetch ? 32'(if_data_o) : 32'(d_rdata_o), 32'(exp));
        @(posedge clk_i);
        #1;
        chk({name, "_pulse"}, 32'(fetch ? if_valid_o : d_valid_o), 0);
    endtask

    vec_t vecs [13];

    initial begin
        int n;
        bit sv;
        vecs[0]  = '{OpFetch, 8'h10, 8'h00, 24'hEAEAEA, 1'b0};
        vecs[1]  = '{OpWrite, 8'h11, 8'h05, 24'h0, 1'b0};
        vecs[2]  = '{OpWrite, 8'h12, 8'h06, 24'h0, 1'b0};
        vecs[3]  = '{OpWrite, 8'h13, 8'h07, 24'h0, 1'b0};
        vecs[4]  = '{OpFetch, 8'h11, 8'h00, 24'h070605, 1'b0};
        vecs[5]  = '{OpRead,  8'h11, 8'h00, 24'h000005, 1'b0};
        vecs[6]  = '{OpWrite, 8'hFE, 8'hAA, 24'h0, WP};
        vecs[7]  = '{OpWrite, 8'hFF, 8'hBB, 24'h0, WP};
        vecs[8]  = '{OpWrite, 8'h00, 8'hCC, 24'h0, 1'b0};
        vecs[9]  = '{OpFetch, 8'hFE, 8'h00, WP ? 24'hCCEAEA : 24'hCCBBAA, 1'b0};
        vecs[10] = '{OpFetch, 8'hFF, 8'h00, WP ? 24'hEACCEA : 24'hEACCBB, 1'b0};
        vecs[11] = '{OpRead,  8'h00, 8'h00, 24'h0000CC, 1'b0};
        vecs[12] = '{OpFetch, 8'h10, 8'h00, 24'h0605EA, 1'b0};

        rstn_i    = 1'b0;
        if_req_i  = 1'b0;
        if_addr_i = '0;
        d_req_i   = 1'b0;
        d_we_i    = 1'b0;
        d_addr_i  = '0;
        d_wdata_i = '0;
        #1;
        chk("reset_if_ready", 32'(if_ready_o), 0);
        chk("reset_d_ready", 32'(d_ready_o), 0);
        chk("reset_if_valid", 32'(if_valid_o), 0);
        chk("reset_wp_err", 32'(wp_err_o), 0);
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        wait_ready(n, sv);
        chk("init_len", 32'(n), 256);

        for (int i = 0; i < 13; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            case (vecs[i].op)
                OpWrite: do_write(nm, vecs[i].addr, vecs[i].wdata, vecs[i].exp_wp);
                OpRead:  do_read(nm, 1'b0, vecs[i].addr, vecs[i].exp);
                default: do_read(nm, 1'b1, vecs[i].addr, vecs[i].exp);
            endcase
        end

        // Back-to-back data reads, then hold of last data
        @(negedge clk_i);
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_addr_i = 8'h11;
        @(negedge clk_i);
        d_addr_i = 8'h12;
        @(posedge clk_i);
        #1;
        chk("b2b_v0", 32'(d_valid_o), 1);
        chk("b2b_d0", 32'(d_rdata_o), 32'h05);
        d_req_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("b2b_v1", 32'(d_valid_o), 1);
        chk("b2b_d1", 32'(d_rdata_o), 32'h06);
        @(posedge clk_i);
        #1;
        chk("b2b_end", 32'(d_valid_o), 0);
        chk("b2b_hold", 32'(d_rdata_o), 32'h06);

        // Same-edge write and fetch on 0x20: fetch sees the old byte
        @(negedge clk_i);
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 8'h20;
        d_wdata_i = 8'h77;
        if_req_i  = 1'b1;
        if_addr_i = 8'h20;
        @(posedge clk_i);
        #1;
        d_req_i  = 1'b0;
        d_we_i   = 1'b0;
        if_req_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("coll_valid", 32'(if_valid_o), 1);
        chk("coll_old", 32'(if_data_o[7:0]), 32'hEA);
        do_read("coll_new", 1'b1, 8'h20, 24'hEAEA77);

        // Write-protect boundary around ROM_BASE=0xC0
        do_write("wp_c5", 8'hC5, 8'h12, WP);
        do_read("wp_c5_rd", 1'b0, 8'hC5, WP ? 24'h0000EA : 24'h000012);
        do_write("wp_bf", 8'hBF, 8'h34, 1'b0);
        do_read("wp_bf_rd", 1'b0, 8'hBF, 24'h000034);

        // Reset while a data read is in flight
        @(negedge clk_i);
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_addr_i = 8'h11;
        @(posedge clk_i);
        #1;
        d_req_i = 1'b0;
        #1;
        rstn_i = 1'b0;
        #1;
        chk("rst_run_dvalid", 32'(d_valid_o), 0);
        chk("rst_run_rdata", 32'(d_rdata_o), 0);
        chk("rst_run_ifdata", 32'(if_data_o), 0);
        chk("rst_run_ready", 32'(d_ready_o), 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        wait_ready(n, sv);
        chk("rst_run_len", 32'(n), 256);
        chk("rst_run_no_valid", 32'(sv), 0);

        // Reset at init count 100
        @(negedge clk_i);
        rstn_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (100) @(posedge clk_i);
        #2;
        chk("mid_init_ready", 32'(if_ready_o), 0);
        rstn_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        wait_ready(n, sv);
        chk("mid_init_len", 32'(n), 256);

        // Full refill after init
        do_read("refill_f", 1'b1, 8'h11, 24'hEAEAEA);
        do_read("refill_d", 1'b0, 8'h20, 24'h0000EA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
